// File: rtl/ray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ray_pkg
// Description : Shared fixed-point type, FSM encoding and default raster size
//               for the ray direction generator.
// Revision    : 1.0 - initial release
// ============================================================================
package ray_pkg;

    localparam int FRAC_BITS          = 16;
    localparam int c_h_res_default    = 640;
    localparam int c_v_res_default    = 480;
    localparam int c_uv_shift_default = 9;

    typedef logic signed [31:0] q16_16_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ray_state_t;

endpackage
`default_nettype wire

// File: rtl/fx_mul.sv
`default_nettype none
// ============================================================================
// Module      : fx_mul
// Description : Signed Q16.16 multiply; full 64-bit product, arithmetic shift
//               right by FRAC_BITS, truncated back to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module fx_mul
    import ray_pkg::*;
(
    input  q16_16_t i_a,
    input  q16_16_t i_b,
    output q16_16_t o_p
);

    logic signed [63:0] w_a;
    logic signed [63:0] w_b;
    logic signed [63:0] w_full;

    assign w_a    = {{32{i_a[31]}}, i_a};
    assign w_b    = {{32{i_b[31]}}, i_b};
    assign w_full = w_a * w_b;
    assign o_p    = 32'(w_full >>> FRAC_BITS);

endmodule
`default_nettype wire

// File: rtl/ray_dir_gen.sv
`default_nettype none
// ============================================================================
// Module      : ray_dir_gen
// Description : Raster-order camera ray generator; 3-stage pipeline producing
//               rotated Q16.16 ray directions with a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module ray_dir_gen
    import ray_pkg::*;
#(
    parameter int H_RES    = c_h_res_default,
    parameter int V_RES    = c_v_res_default,
    parameter int UV_SHIFT = c_uv_shift_default
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [31:0] lookat_1_1,
    input  logic [31:0] lookat_1_2,
    input  logic [31:0] lookat_1_3,
    input  logic [31:0] lookat_2_1,
    input  logic [31:0] lookat_2_2,
    input  logic [31:0] lookat_2_3,
    input  logic [31:0] lookat_3_1,
    input  logic [31:0] lookat_3_2,
    input  logic [31:0] lookat_3_3,
    input  logic [31:0] eye_x,
    input  logic [31:0] eye_y,
    input  logic [31:0] eye_z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_dir_x,
    output logic [31:0] out_dir_y,
    output logic [31:0] out_dir_z,
    output logic [31:0] out_eye_x,
    output logic [31:0] out_eye_y,
    output logic [31:0] out_eye_z,
    output logic [9:0]  out_px,
    output logic [8:0]  out_py,
    output logic        out_last,
    output logic        busy,
    output logic        frame_done
);

    localparam int          c_uv_sh  = FRAC_BITS - UV_SHIFT;
    localparam logic [9:0]  c_x_max  = 10'(H_RES - 1);
    localparam logic [8:0]  c_y_max  = 9'(V_RES - 1);
    localparam logic [31:0] c_half_h = 32'(H_RES / 2);
    localparam logic [31:0] c_half_v = 32'(V_RES / 2);

    ray_state_t  r_state, w_state_next;
    q16_16_t     w_m_in [3][3];
    q16_16_t     r_m    [3][3];
    logic [31:0] w_eye_in [3];
    logic [31:0] r_eye    [3];
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic        w_advance, w_start, w_issue, w_pix_last, w_accept_last;
    logic [31:0] w_u, w_v;

    logic        r_s1_valid, r_s1_last;
    logic [9:0]  r_s1_px;
    logic [8:0]  r_s1_py;
    q16_16_t     r_s1_uv [2];

    logic        r_s2_valid, r_s2_last;
    logic [9:0]  r_s2_px;
    logic [8:0]  r_s2_py;
    q16_16_t     w_prod [3][2];
    q16_16_t     r_prod [3][2];

    logic        r_s3_valid, r_s3_last;
    logic [9:0]  r_s3_px;
    logic [8:0]  r_s3_py;
    logic [31:0] r_dir [3];
    logic        r_frame_done;

    assign w_m_in[0][0] = lookat_1_1;
    assign w_m_in[0][1] = lookat_1_2;
    assign w_m_in[0][2] = lookat_1_3;
    assign w_m_in[1][0] = lookat_2_1;
    assign w_m_in[1][1] = lookat_2_2;
    assign w_m_in[1][2] = lookat_2_3;
    assign w_m_in[2][0] = lookat_3_1;
    assign w_m_in[2][1] = lookat_3_2;
    assign w_m_in[2][2] = lookat_3_3;
    assign w_eye_in[0]  = eye_x;
    assign w_eye_in[1]  = eye_y;
    assign w_eye_in[2]  = eye_z;

    assign w_advance     = !r_s3_valid || out_ready;
    assign w_start       = (r_state == ST_IDLE) && frame_start;
    assign w_issue       = (r_state == ST_RUN) && w_advance;
    assign w_pix_last    = (r_x == c_x_max) && (r_y == c_y_max);
    assign w_accept_last = r_s3_valid && out_ready && r_s3_last;

    // Screen-space offsets; wrap-around 32-bit arithmetic yields the signed result.
    assign w_u = (32'(r_x) - c_half_h) << c_uv_sh;
    assign w_v = (c_half_v - 32'(r_y)) << c_uv_sh;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (frame_start)             w_state_next = ST_RUN;
            ST_RUN:   if (w_issue && w_pix_last)   w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_accept_last)           w_state_next = ST_IDLE;
            default:                               w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_frame_done <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            for (int r = 0; r < 3; r++) begin
                r_eye[r] <= '0;
                for (int c = 0; c < 3; c++) r_m[r][c] <= '0;
            end
        end else begin
            r_state      <= w_state_next;
            r_frame_done <= w_accept_last;
            if (w_start) begin
                r_x <= '0;
                r_y <= '0;
                for (int r = 0; r < 3; r++) begin
                    r_eye[r] <= w_eye_in[r];
                    for (int c = 0; c < 3; c++) r_m[r][c] <= w_m_in[r][c];
                end
            end else if (w_issue) begin
                if (r_x == c_x_max) begin
                    r_x <= '0;
                    r_y <= (r_y == c_y_max) ? '0 : r_y + 9'd1;
                end else begin
                    r_x <= r_x + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_px    <= '0;
            r_s1_py    <= '0;
            r_s1_uv[0] <= '0;
            r_s1_uv[1] <= '0;
        end else if (w_advance) begin
            r_s1_valid <= (r_state == ST_RUN);
            r_s1_last  <= (r_state == ST_RUN) && w_pix_last;
            r_s1_px    <= r_x;
            r_s1_py    <= r_y;
            r_s1_uv[0] <= w_u;
            r_s1_uv[1] <= w_v;
        end
    end

    for (genvar gr = 0; gr < 3; gr++) begin : g_row
        for (genvar gc = 0; gc < 2; gc++) begin : g_col
            fx_mul u_mul (
                .i_a (r_m[gr][gc]),
                .i_b (r_s1_uv[gc]),
                .o_p (w_prod[gr][gc])
            );
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_px    <= '0;
            r_s2_py    <= '0;
            r_s3_valid <= 1'b0;
            r_s3_last  <= 1'b0;
            r_s3_px    <= '0;
            r_s3_py    <= '0;
            for (int r = 0; r < 3; r++) begin
                r_dir[r]     <= '0;
                r_prod[r][0] <= '0;
                r_prod[r][1] <= '0;
            end
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_px    <= r_s1_px;
            r_s2_py    <= r_s1_py;
            r_s3_valid <= r_s2_valid;
            r_s3_last  <= r_s2_last;
            r_s3_px    <= r_s2_px;
            r_s3_py    <= r_s2_py;
            for (int r = 0; r < 3; r++) begin
                r_prod[r][0] <= w_prod[r][0];
                r_prod[r][1] <= w_prod[r][1];
                r_dir[r]     <= r_prod[r][0] + r_prod[r][1] + r_m[r][2];
            end
        end
    end

    assign out_valid  = r_s3_valid;
    assign out_last   = r_s3_last;
    assign out_px     = r_s3_px;
    assign out_py     = r_s3_py;
    assign out_dir_x  = r_dir[0];
    assign out_dir_y  = r_dir[1];
    assign out_dir_z  = r_dir[2];
    assign out_eye_x  = r_eye[0];
    assign out_eye_y  = r_eye[1];
    assign out_eye_z  = r_eye[2];
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ray_dir_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ray_dir_gen
// Description : Scoreboard bench for ray_dir_gen; full-size instance for value
//               and stall checks, small-raster instance for whole-frame checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ray_dir_gen;

    localparam int c_sh_h  = 20;
    localparam int c_sh_v  = 6;
    localparam int c_sh_uv = 8;

    typedef struct packed {
        logic [31:0] dx, dy, dz, ex, ey, ez;
        logic [9:0]  px;
        logic [8:0]  py;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        out_ready = 1'b0;
    logic        sel = 1'b0;
    logic        exp_done = 1'b0;
    logic [31:0] m [3][3];
    logic [31:0] e [3];
    logic [31:0] snap_m [3][3];
    logic [31:0] snap_e [3];
    beat_t       q_exp [$];
    int          n_checks = 0;
    int          n_errors = 0;

    logic        a_valid, a_last, a_busy, a_done, b_valid, b_last, b_busy, b_done;
    logic [31:0] a_dx, a_dy, a_dz, a_ex, a_ey, a_ez, b_dx, b_dy, b_dz, b_ex, b_ey, b_ez;
    logic [9:0]  a_px, b_px;
    logic [8:0]  a_py, b_py;
    beat_t       obs;
    logic        mon_valid, mon_busy, mon_done;

    always #5 clk = ~clk;

    ray_dir_gen dut_a (
        .clk(clk), .reset(reset), .frame_start(frame_start && !sel),
        .lookat_1_1(m[0][0]), .lookat_1_2(m[0][1]), .lookat_1_3(m[0][2]),
        .lookat_2_1(m[1][0]), .lookat_2_2(m[1][1]), .lookat_2_3(m[1][2]),
        .lookat_3_1(m[2][0]), .lookat_3_2(m[2][1]), .lookat_3_3(m[2][2]),
        .eye_x(e[0]), .eye_y(e[1]), .eye_z(e[2]),
        .out_valid(a_valid), .out_ready(out_ready && !sel),
        .out_dir_x(a_dx), .out_dir_y(a_dy), .out_dir_z(a_dz),
        .out_eye_x(a_ex), .out_eye_y(a_ey), .out_eye_z(a_ez),
        .out_px(a_px), .out_py(a_py), .out_last(a_last),
        .busy(a_busy), .frame_done(a_done)
    );

    ray_dir_gen #(.H_RES(c_sh_h), .V_RES(c_sh_v), .UV_SHIFT(c_sh_uv)) dut_b (
        .clk(clk), .reset(reset), .frame_start(frame_start && sel),
        .lookat_1_1(m[0][0]), .lookat_1_2(m[0][1]), .lookat_1_3(m[0][2]),
        .lookat_2_1(m[1][0]), .lookat_2_2(m[1][1]), .lookat_2_3(m[1][2]),
        .lookat_3_1(m[2][0]), .lookat_3_2(m[2][1]), .lookat_3_3(m[2][2]),
        .eye_x(e[0]), .eye_y(e[1]), .eye_z(e[2]),
        .out_valid(b_valid), .out_ready(out_ready && sel),
        .out_dir_x(b_dx), .out_dir_y(b_dy), .out_dir_z(b_dz),
        .out_eye_x(b_ex), .out_eye_y(b_ey), .out_eye_z(b_ez),
        .out_px(b_px), .out_py(b_py), .out_last(b_last),
        .busy(b_busy), .frame_done(b_done)
    );

    always_comb begin
        obs       = '{a_dx, a_dy, a_dz, a_ex, a_ey, a_ez, a_px, a_py, a_last};
        mon_valid = a_valid;
        mon_busy  = a_busy;
        mon_done  = a_done;
        if (sel) begin
            obs       = '{b_dx, b_dy, b_dz, b_ex, b_ey, b_ez, b_px, b_py, b_last};
            mon_valid = b_valid;
            mon_busy  = b_busy;
            mon_done  = b_done;
        end
    end

    // Reference: pixel -> (u,v) -> rotated direction, from the frame snapshot.
    function automatic beat_t model(input int x, input int y);
        int          h, vres, sh;
        longint      u, w, p0, p1;
        logic [31:0] d [3];
        h    = sel ? c_sh_h : 640;
        vres = sel ? c_sh_v : 480;
        sh   = sel ? c_sh_uv : 9;
        u = longint'(x - h / 2) * (longint'(1) << (16 - sh));
        w = longint'(vres / 2 - y) * (longint'(1) << (16 - sh));
        for (int r = 0; r < 3; r++) begin
            p0 = (longint'($signed(snap_m[r][0])) * u) >>> 16;
            p1 = (longint'($signed(snap_m[r][1])) * w) >>> 16;
            d[r] = 32'(p0) + 32'(p1) + snap_m[r][2];
        end
        return '{d[0], d[1], d[2], snap_e[0], snap_e[1], snap_e[2],
                 10'(x), 9'(y), (x == h - 1) && (y == vres - 1)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_identity();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) m[r][c] = (r == c) ? 32'h0001_0000 : 32'h0;
        e[0] = 32'h0001_0000; e[1] = 32'h0002_8000; e[2] = 32'hFFFD_0000;
    endtask

    task automatic set_random();
        for (int r = 0; r < 3; r++) begin
            e[r] = $urandom;
            for (int c = 0; c < 3; c++) m[r][c] = $urandom;
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1; frame_start = 1'b0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        q_exp.delete();
        exp_done = 1'b0;
        step();
    endtask

    task automatic start_frame(input int n);
        int h;
        h = sel ? c_sh_h : 640;
        snap_m = m;
        snap_e = e;
        for (int i = 0; i < n; i++) q_exp.push_back(model(i % h, i / h));
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic consume(input int n, input int pct, input bit fs_on_last);
        int    got, cyc;
        bit    rdy, hold;
        beat_t held, exp;
        got = 0; cyc = 0; hold = 1'b0; held = '0;
        while (got < n && cyc < n * 8 + 50) begin
            rdy = ($urandom_range(99) < pct);
            out_ready = rdy;
            if (hold) begin
                n_checks++;
                if (mon_valid !== 1'b1 || obs !== held) begin
                    n_errors++;
                    $display("FAIL stall_hold: got valid=%b beat=%h, required valid=1 beat=%h", mon_valid, obs, held);
                end
            end
            n_checks++;
            if (mon_done !== exp_done) begin
                n_errors++;
                $display("FAIL frame_done: got %b, required %b", mon_done, exp_done);
            end
            exp_done = 1'b0;
            if (mon_valid && rdy) begin
                n_checks++;
                if (q_exp.size() == 0) begin
                    n_errors++;
                    $display("FAIL extra_beat: got beat %h, required none", obs);
                end else begin
                    exp = q_exp.pop_front();
                    if (obs !== exp) begin
                        n_errors++;
                        $display("FAIL beat: got %h, required %h", obs, exp);
                    end
                end
                got++;
                if (obs.last) begin
                    exp_done = 1'b1;
                    if (fs_on_last) frame_start = 1'b1;
                end
            end
            hold = mon_valid && !rdy;
            held = obs;
            step();
            frame_start = 1'b0;
            cyc++;
        end
        n_checks++;
        if (got != n) begin
            n_errors++;
            $display("FAIL beat_count: got %0d beats, required %0d", got, n);
        end
    endtask

    task automatic check_frame_end();
        n_checks++;
        if (mon_done !== 1'b1 || mon_busy !== 1'b0 || mon_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_end: got done=%b busy=%b valid=%b, required 1 0 0", mon_done, mon_busy, mon_valid);
        end
        exp_done = 1'b0;
        step();
        n_checks++;
        if (mon_done !== 1'b0 || mon_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL done_pulse: got done=%b busy=%b, required 0 0", mon_done, mon_busy);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            set_random();
            reset = 1'b1;
            step();
            n_checks++;
            if (mon_valid !== 1'b0 || mon_busy !== 1'b0 || mon_done !== 1'b0 || obs !== '0) begin
                n_errors++;
                $display("FAIL reset_state: got valid=%b busy=%b done=%b beat=%h, required all 0", mon_valid, mon_busy, mon_done, obs);
            end
        end
    endtask

    task automatic test_first_beat();
        sel = 1'b0;
        set_identity();
        reset_dut();
        out_ready = 1'b1;
        start_frame(640);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (mon_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL latency_early: got valid=%b at edge N+%0d, required 0", mon_valid, k);
            end
            step();
        end
        n_checks++;
        if (mon_valid !== 1'b1 || obs.px !== 10'd0 || obs.py !== 9'd0 || obs.dx !== 32'hFFFF_6000
            || obs.dy !== 32'h0000_7800 || obs.dz !== 32'h0001_0000) begin
            n_errors++;
            $display("FAIL first_beat: got valid=%b px=%0d py=%0d dir=%h %h %h, required 1 0 0 ffff6000 00007800 00010000",
                     mon_valid, obs.px, obs.py, obs.dx, obs.dy, obs.dz);
        end
        consume(640, 100, 1'b0);
    endtask

    task automatic test_scale();
        sel = 1'b0;
        set_identity();
        m[0][0] = 32'h0002_0000;
        reset_dut();
        start_frame(640);
        consume(639, 100, 1'b0);
        n_checks++;
        if (mon_valid !== 1'b1 || obs.px !== 10'd639 || obs.dx !== 32'h0001_3F00) begin
            n_errors++;
            $display("FAIL scale_x639: got valid=%b px=%0d dir_x=%h, required 1 639 00013f00", mon_valid, obs.px, obs.dx);
        end
        consume(1, 100, 1'b0);
    endtask

    task automatic test_random_stall();
        sel = 1'b0;
        set_random();
        reset_dut();
        start_frame(1500);
        consume(1500, 50, 1'b0);
    endtask

    task automatic test_reset_midframe();
        sel = 1'b0;
        set_random();
        reset_dut();
        start_frame(1000);
        consume(1000, 100, 1'b0);
        reset = 1'b1;
        #1;
        n_checks++;
        if (mon_valid !== 1'b0 || mon_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got valid=%b busy=%b, required 0 0", mon_valid, mon_busy);
        end
        step();
        reset = 1'b0;
        q_exp.delete();
        exp_done = 1'b0;
        step();
        start_frame(5);
        consume(5, 100, 1'b0);
    endtask

    task automatic test_full_frame();
        sel = 1'b1;
        set_random();
        reset_dut();
        start_frame(c_sh_h * c_sh_v);
        consume(c_sh_h * c_sh_v, 100, 1'b0);
        check_frame_end();
    endtask

    task automatic test_midframe_change();
        sel = 1'b1;
        set_random();
        reset_dut();
        start_frame(c_sh_h * c_sh_v);
        set_random();
        consume(60, 50, 1'b0);
        set_random();
        consume(c_sh_h * c_sh_v - 60, 50, 1'b0);
        check_frame_end();
        start_frame(c_sh_h * c_sh_v);
        consume(c_sh_h * c_sh_v, 50, 1'b0);
        check_frame_end();
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        set_random();
        reset_dut();
        start_frame(c_sh_h * c_sh_v);
        consume(50, 70, 1'b0);
        out_ready = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        consume(c_sh_h * c_sh_v - 50, 70, 1'b1);
        n_checks++;
        if (mon_busy !== 1'b0 || mon_done !== 1'b1) begin
            n_errors++;
            $display("FAIL start_on_last: got busy=%b done=%b, required 0 1", mon_busy, mon_done);
        end
        exp_done = 1'b0;
        start_frame(c_sh_h * c_sh_v);
        consume(c_sh_h * c_sh_v, 100, 1'b0);
        check_frame_end();
    endtask

    initial begin
        set_identity();
        test_reset();
        test_first_beat();
        test_scale();
        test_random_stall();
        test_reset_midframe();
        test_full_frame();
        test_midframe_change();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
